// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared definitions for the UART packet framer.
//   - state_t      : framer states IDLE / PAYLOAD / CHECK
//   - ERR_*        : err_code values reported alongside frame_err
//   - HDR_MARK_DEF : default upper byte that marks a header word
//   - len_ok()     : header length legality test (1..max_len)
package uart_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_BAD_LEN = 2'd0;
    localparam logic [1:0] ERR_BAD_SUM = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [7:0] HDR_MARK_DEF = 8'hA5;

    // A header length is usable when it is non-zero and fits the payload limit.
    function automatic logic len_ok(input logic [7:0] n, input int max_len);
        return (n != 8'd0) && (int'(n) <= max_len);
    endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// uart_pkt_timeout: inter-word gap counter for the packet framer.
// Only instantiated when UART_PKT_TIMEOUT_EN is defined.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   clr    in  clear the count (word popped, or framer idle)
//   en     in  count this cycle (framer starved by an empty FIFO)
//   expire out high in the cycle the count sits at TIMEOUT_CYCLES-1 while enabled
module uart_pkt_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_BITS        = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TO_BITS-1:0] LAST_COUNT = TO_BITS'(TIMEOUT_CYCLES - 1);

    logic [TO_BITS-1:0] count_r;

    // Gap counter: clear has priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {TO_BITS{1'b0}};
        end else if (clr) begin
            count_r <= {TO_BITS{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(TO_BITS-1){1'b0}}, 1'b1};
        end
    end

    assign expire = en & (count_r == LAST_COUNT);

endmodule

// File: rtl/uart_packet_rx.sv
// uart_packet_rx: framing stage behind a show-ahead 16-bit UART RX FIFO.
// Hunts for a header word {HDR_MARK, N}, streams N payload words out on a
// valid/ready port, then checks the trailing word against the 16-bit
// modulo sum of header and payload.
// Optional build macro: UART_PKT_TIMEOUT_EN adds an inter-word timeout
// (err_code 2); without it a stalled frame waits indefinitely.
// Ports:
//   clk_100MHz in  system clock
//   reset      in  asynchronous active-high reset
//   rx_data    in  FIFO head word (valid while rx_empty is low)
//   rx_empty   in  FIFO empty
//   rx_rd      out pop strobe, word on rx_data consumed in the same cycle
//   pl_data    out payload word
//   pl_valid   out pl_data valid
//   pl_ready   in  consumer accepts when pl_valid & pl_ready
//   pl_first   out first payload word of a frame
//   pl_last    out last payload word of a frame
//   frame_len  out length field of the most recent valid header
//   frame_ok   out one-cycle pulse, checksum matched
//   frame_err  out one-cycle pulse, frame bad or aborted
//   err_code   out reason for frame_err: 0 bad length, 1 bad sum, 2 timeout
module uart_packet_rx
    import uart_pkt_pkg::*;
#(
    parameter int         DBITS          = 16,
    parameter logic [7:0] HDR_MARK       = HDR_MARK_DEF,
    parameter int         MAX_LEN        = 32,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         TO_BITS        = 20
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [DBITS-1:0] rx_data,
    input  logic             rx_empty,
    output logic             rx_rd,
    output logic [DBITS-1:0] pl_data,
    output logic             pl_valid,
    input  logic             pl_ready,
    output logic             pl_first,
    output logic             pl_last,
    output logic [7:0]       frame_len,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [1:0]       err_code
);

    // Reject parameter sets the header layout and counter cannot support.
    if (DBITS != 16 || MAX_LEN < 1 || MAX_LEN > 255 ||
        64'(TIMEOUT_CYCLES) >= (64'd1 << TO_BITS)) begin : g_cfg_error
        $error("uart_packet_rx: illegal parameter set");
    end

    state_t           state_r;
    logic [DBITS-1:0] sum_r;
    logic [7:0]       idx_r;
    logic [7:0]       frame_len_r;
    logic [DBITS-1:0] pl_data_r;
    logic             pl_valid_r;
    logic             pl_first_r;
    logic             pl_last_r;
    logic             frame_ok_r;
    logic             frame_err_r;
    logic [1:0]       err_code_r;

    logic             wants_s;
    logic             pop_s;
    logic             accept_s;
    logic             is_hdr_s;
    logic [7:0]       hdr_len_s;
    logic             last_word_s;
    logic [DBITS-1:0] sum_next_s;
    logic             to_expire_s;

    // IDLE drains the FIFO freely (headers never touch the output register);
    // PAYLOAD and CHECK only pop when the output register is free or being
    // accepted, so the last payload word always leaves before the result.
    assign wants_s     = (state_r == IDLE) | ~pl_valid_r | pl_ready;
    assign pop_s       = ~reset & ~rx_empty & wants_s;
    assign accept_s    = pl_valid_r & pl_ready;
    assign is_hdr_s    = (rx_data[DBITS-1 -: 8] == HDR_MARK);
    assign hdr_len_s   = rx_data[7:0];
    assign last_word_s = (idx_r == (frame_len_r - 8'd1));
    assign sum_next_s  = sum_r + rx_data;

`ifdef UART_PKT_TIMEOUT_EN
    logic to_en_s;
    logic to_clr_s;

    // Only count starvation by the FIFO, never consumer back-pressure.
    assign to_en_s  = (state_r != IDLE) & rx_empty & (~pl_valid_r | pl_ready);
    assign to_clr_s = pop_s | (state_r == IDLE);

    uart_pkt_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_BITS        (TO_BITS)
    ) u_timeout (
        .clk    (clk_100MHz),
        .reset  (reset),
        .clr    (to_clr_s),
        .en     (to_en_s),
        .expire (to_expire_s)
    );
`else
    assign to_expire_s = 1'b0;
`endif

    // Framer FSM with registered payload port and result pulses.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            sum_r       <= {DBITS{1'b0}};
            idx_r       <= 8'd0;
            frame_len_r <= 8'd0;
            pl_data_r   <= {DBITS{1'b0}};
            pl_valid_r  <= 1'b0;
            pl_first_r  <= 1'b0;
            pl_last_r   <= 1'b0;
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            err_code_r  <= 2'd0;
        end else begin
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            // A held word leaves on acceptance; a same-cycle load below wins.
            if (accept_s) begin
                pl_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (pop_s && is_hdr_s) begin
                        if (len_ok(hdr_len_s, MAX_LEN)) begin
                            frame_len_r <= hdr_len_s;
                            sum_r       <= rx_data;
                            idx_r       <= 8'd0;
                            state_r     <= PAYLOAD;
                        end else begin
                            frame_err_r <= 1'b1;
                            err_code_r  <= ERR_BAD_LEN;
                        end
                    end
                end
                PAYLOAD: begin
                    if (to_expire_s) begin
                        frame_err_r <= 1'b1;
                        err_code_r  <= ERR_TIMEOUT;
                        state_r     <= IDLE;
                    end else if (pop_s) begin
                        // Header-looking words are plain payload here.
                        pl_data_r  <= rx_data;
                        pl_valid_r <= 1'b1;
                        pl_first_r <= (idx_r == 8'd0);
                        pl_last_r  <= last_word_s;
                        sum_r      <= sum_next_s;
                        idx_r      <= idx_r + 8'd1;
                        if (last_word_s) begin
                            state_r <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (to_expire_s) begin
                        frame_err_r <= 1'b1;
                        err_code_r  <= ERR_TIMEOUT;
                        state_r     <= IDLE;
                    end else if (pop_s) begin
                        if (rx_data == sum_r) begin
                            frame_ok_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                            err_code_r  <= ERR_BAD_SUM;
                        end
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rx_rd     = pop_s;
    assign pl_data   = pl_data_r;
    assign pl_valid  = pl_valid_r;
    assign pl_first  = pl_first_r;
    assign pl_last   = pl_last_r;
    assign frame_len = frame_len_r;
    assign frame_ok  = frame_ok_r;
    assign frame_err = frame_err_r;
    assign err_code  = err_code_r;

endmodule

// File: tb/tb_uart_packet_rx.sv
// tb_uart_packet_rx: directed + randomized bench for uart_packet_rx.
// A queue models the show-ahead FIFO; expected payload words and frame
// results are computed per frame from the framing/checksum rules.
module tb_uart_packet_rx;

    localparam int MAX_LEN = 32;
    localparam int TO_CYC  = 100;
    localparam int TO_BITS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rx_data;
    logic        rx_empty;
    logic        rx_rd;
    logic [15:0] pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic        pl_first;
    logic        pl_last;
    logic [7:0]  frame_len;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    uart_packet_rx #(
        .DBITS          (16),
        .HDR_MARK       (8'hA5),
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TO_CYC),
        .TO_BITS        (TO_BITS)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .rx_rd      (rx_rd),
        .pl_data    (pl_data),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .pl_first   (pl_first),
        .pl_last    (pl_last),
        .frame_len  (frame_len),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    typedef struct packed {
        logic        first;
        logic        last;
        logic [15:0] data;
    } pl_exp_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] code;
        logic [7:0] delay;    // cycles from last pop to the result pulse
        logic       drained;  // all payload of this frame delivered first
    } res_exp_t;

    logic [15:0] fifo[$];
    logic [15:0] pay_q[$];
    pl_exp_t     exp_pl[$];
    res_exp_t    exp_res[$];

    int          tests_run    = 0;
    int          fail_cnt     = 0;
    int          cyc          = 0;
    int          last_pop_cyc = 0;
    int          ready_mode   = 0;
    int          stall_n      = 0;
    bit          pop_pending  = 1'b0;
    bit          prev_stall   = 1'b0;
    logic [17:0] prev_out     = 18'd0;
    logic [7:0]  exp_len      = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_inputs();
        rx_empty = (fifo.size() == 0);
        rx_data  = rx_empty ? 16'($urandom) : fifo[0];
        case (ready_mode)
            0: pl_ready = 1'b1;
            1: pl_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (pl_valid && stall_n < 5) begin
                    pl_ready = 1'b0;
                    stall_n++;
                end else begin
                    pl_ready = 1'b1;
                end
            end
            default: pl_ready = 1'b0;
        endcase
    endtask

    task automatic monitor();
        pl_exp_t  e;
        res_exp_t r;
        if (prev_stall) begin
            check("pl_valid_hold", 32'(pl_valid), 32'd1);
            check("pl_out_hold", 32'({pl_first, pl_last, pl_data}), 32'(prev_out));
        end
        if (pl_valid && !pl_ready) begin
            check("rx_rd_while_stalled", 32'(rx_rd), 32'd0);
        end
        if (pl_valid && pl_ready) begin
            stall_n = 0;
            if (exp_pl.size() == 0) begin
                check("word_unexpected", {16'd0, pl_data}, 32'h0001_0000);
            end else begin
                e = exp_pl.pop_front();
                check("pl_word", 32'({pl_first, pl_last, pl_data}), 32'(e));
            end
        end
        if (frame_ok || frame_err) begin
            if (exp_res.size() == 0) begin
                check("result_unexpected", 32'({frame_ok, frame_err, err_code}), 32'h100);
            end else begin
                r = exp_res.pop_front();
                check("result", 32'({frame_ok, frame_err, frame_err ? err_code : 2'd0}),
                      32'({r.ok, ~r.ok, r.ok ? 2'd0 : r.code}));
                check("result_delay", 32'(cyc - last_pop_cyc), 32'(r.delay));
                if (r.drained) begin
                    check("delivered_before_result", 32'(exp_pl.size()), 32'd0);
                end
            end
        end
        prev_stall  = pl_valid && !pl_ready;
        prev_out    = {pl_first, pl_last, pl_data};
        pop_pending = rx_rd;
        if (rx_rd) begin
            last_pop_cyc = cyc;
        end
    endtask

    // One clock: retire the word popped at this edge, drive, sample on negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_pending && fifo.size() != 0) begin
            void'(fifo.pop_front());
        end
        pop_pending = 1'b0;
        drive_inputs();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while ((fifo.size() != 0 || exp_pl.size() != 0 || exp_res.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_within_budget", 32'(fifo.size() + exp_pl.size() + exp_res.size()), 32'd0);
        repeat (3) tick();
    endtask

    // Header + pay_q payload + check word (sum + delta); delta != 0 is a bad sum.
    task automatic send_frame(input logic [15:0] delta);
        int          n;
        logic [15:0] hdr;
        logic [15:0] sum;
        n   = pay_q.size();
        hdr = {8'hA5, 8'(n)};
        sum = hdr;
        fifo.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            fifo.push_back(pay_q[i]);
            sum = sum + pay_q[i];
            exp_pl.push_back('{first: (i == 0), last: (i == n - 1), data: pay_q[i]});
        end
        fifo.push_back(sum + delta);
        exp_res.push_back('{ok: (delta == 16'd0), code: 2'd1, delay: 8'd1, drained: 1'b1});
        exp_len = 8'(n);
        pay_q.delete();
    endtask

    task automatic send_bad_hdr(input logic [7:0] n);
        fifo.push_back({8'hA5, n});
        exp_res.push_back('{ok: 1'b0, code: 2'd0, delay: 8'd1, drained: 1'b0});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          n;
        logic [15:0] d;

        // Reset state, with a non-empty FIFO to show rx_rd is held off.
        reset    = 1'b1;
        rx_empty = 1'b0;
        rx_data  = 16'hA502;
        pl_ready = 1'b1;
        #2;
        check("reset_ctrl", 32'({rx_rd, pl_valid, pl_first, pl_last, frame_ok, frame_err, err_code}), 32'd0);
        check("reset_data", 32'({frame_len, pl_data}), 32'd0);
        rx_empty = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Good frame: 0xA502 + 0x1234 + 0x0001 = 0xB737.
        pay_q.push_back(16'h1234);
        pay_q.push_back(16'h0001);
        send_frame(16'd0);
        run_until_done(100);
        check("frame_len_good", 32'(frame_len), 32'd2);

        // Same frame, check word 0xB738 (one off).
        pay_q.push_back(16'h1234);
        pay_q.push_back(16'h0001);
        send_frame(16'd1);
        run_until_done(100);

        // Garbage word, zero length, over-long length, then a 1-word frame.
        fifo.push_back(16'h0055);
        send_bad_hdr(8'h00);
        send_bad_hdr(8'h21);
        pay_q.push_back(16'h0007);
        send_frame(16'd0);
        run_until_done(100);
        check("frame_len_after_bad", 32'(frame_len), 32'd1);

        // Back-pressure: 5 stalled cycles on each of 3 words.
        ready_mode = 2;
        for (int i = 0; i < 3; i++) pay_q.push_back(16'($urandom));
        send_frame(16'd0);
        run_until_done(200);
        ready_mode = 0;

        // Randomized frames, including boundary lengths 1 and MAX_LEN.
        for (int it = 0; it < 12; it++) begin
            ready_mode = 1;
            if ($urandom_range(0, 2) == 0) begin
                w = 16'($urandom);
                if (w[15:8] == 8'hA5) w[15:8] = 8'h5A;
                fifo.push_back(w);
            end
            if ($urandom_range(0, 3) == 0) begin
                send_bad_hdr(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(33, 255)));
            end
            n = (it == 0) ? 1 : (it == 1) ? MAX_LEN : int'($urandom_range(1, MAX_LEN));
            for (int i = 0; i < n; i++) pay_q.push_back(16'($urandom));
            d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0;
            send_frame(d);
            run_until_done(2000);
            check("frame_len_rand", 32'(frame_len), 32'(n));
        end
        ready_mode = 0;

        // Starved frame: A503, 0001, then the FIFO runs dry.
        fifo.push_back(16'hA503);
        fifo.push_back(16'h0001);
        exp_pl.push_back('{first: 1'b1, last: 1'b0, data: 16'h0001});
`ifdef UART_PKT_TIMEOUT_EN
        // 100 counted empty cycles after the pop, pulse registered the cycle after.
        exp_res.push_back('{ok: 1'b0, code: 2'd2, delay: 8'(TO_CYC + 1), drained: 1'b1});
        run_until_done(400);
        pay_q.push_back(16'h0BAD);
        send_frame(16'd0);
        run_until_done(100);
`else
        repeat (150) tick();
        check("stalled_word_delivered", 32'(exp_pl.size()), 32'd0);
        // A503 + 0001 + 0002 + 0003 = A509.
        fifo.push_back(16'h0002);
        fifo.push_back(16'h0003);
        fifo.push_back(16'hA509);
        exp_pl.push_back('{first: 1'b0, last: 1'b0, data: 16'h0002});
        exp_pl.push_back('{first: 1'b0, last: 1'b1, data: 16'h0003});
        exp_res.push_back('{ok: 1'b1, code: 2'd0, delay: 8'd1, drained: 1'b1});
        run_until_done(100);
        check("frame_len_slow", 32'(frame_len), 32'd3);
`endif

        // Reset in the middle of a frame, with a payload word held.
        ready_mode = 3;
        fifo.push_back(16'hA503);
        fifo.push_back(16'h1111);
        fifo.push_back(16'h2222);
        repeat (4) tick();
        check("held_before_reset", 32'(pl_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_ctrl", 32'({rx_rd, pl_valid, pl_first, pl_last, frame_ok, frame_err, err_code}), 32'd0);
        check("reset_async_data", 32'({frame_len, pl_data}), 32'd0);
        fifo.delete();
        exp_pl.delete();
        exp_res.delete();
        prev_stall = 1'b0;
        stall_n    = 0;
        ready_mode = 0;
        tick();
        #2;
        reset = 1'b0;

        // Clean frame after reset; payload contains a header-looking word.
        pay_q.push_back(16'hA5A5);
        pay_q.push_back(16'hA502);
        pay_q.push_back(16'h0F0F);
        send_frame(16'd0);
        run_until_done(100);
        check("frame_len_after_reset", 32'(frame_len), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
